// File: rtl/stopwatch_counter.sv
// stopwatch_counter: BCD mm:ss stopwatch core with run/pause/adjust FSM and blinking display enable
module stopwatch_counter #(
  parameter int MIN_MAX = 59,
  parameter int SEC_MAX = 59
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ONE_HZ,
  input  logic       ADJ_TICK,
  input  logic       PAUSE,
  input  logic       ADJ,
  input  logic       SEL,
  output logic [3:0] MT,
  output logic [3:0] MO,
  output logic [3:0] ST,
  output logic [3:0] SO,
  output logic       EN,
  output logic [1:0] STATE
);
  typedef enum logic [1:0] {RUN = 2'b00, PAUSED = 2'b01, ADJUST = 2'b10} state_t;
  localparam logic [3:0] MT_MAX = 4'(MIN_MAX / 10);
  localparam logic [3:0] MO_TOP = 4'(MIN_MAX % 10);
  localparam logic [3:0] ST_MAX = 4'(SEC_MAX / 10);
  localparam logic [3:0] SO_TOP = 4'(SEC_MAX % 10);
  state_t state_q, state_d, saved_q, saved_d;
  logic [3:0] mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;
  logic en_q, en_d;
  logic [8:0] sec_n, min_n;
  logic run_inc, adj_s, adj_m;
  // Returns {carry, tens, ones}; out-of-range digits behave as if at their max.
  function automatic logic [8:0] bcd_inc(input logic [3:0] t, o, tm, om);
    logic t_top, o_top;
    t_top = t >= tm;
    o_top = o >= (t_top ? om : 4'd9);
    return o_top ? (t_top ? 9'h100 : {1'b0, t + 4'd1, 4'd0}) : {1'b0, t_top ? tm : t, o + 4'd1};
  endfunction
  always_comb begin
    sec_n   = bcd_inc(st_q, so_q, ST_MAX, SO_TOP);
    min_n   = bcd_inc(mt_q, mo_q, MT_MAX, MO_TOP);
    run_inc = state_q == RUN && ONE_HZ;
    adj_s   = state_q == ADJUST && ADJ_TICK && SEL;
    adj_m   = state_q == ADJUST && ADJ_TICK && !SEL;
    saved_d = (state_q != ADJUST && ADJ) ? state_q : saved_q;
    state_d = state_q == ADJUST ? (ADJ ? ADJUST : saved_q)
            : ADJ ? ADJUST
            : PAUSE ? (state_q == RUN ? PAUSED : RUN)
            : state_q;
    {st_d, so_d} = (run_inc || adj_s) ? sec_n[7:0] : {st_q, so_q};
    {mt_d, mo_d} = (adj_m || (run_inc && sec_n[8])) ? min_n[7:0] : {mt_q, mo_q};
    en_d    = (state_q == ADJUST && ADJ) ? en_q ^ ADJ_TICK : 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      saved_q <= RUN;
      mt_q    <= '0;
      mo_q    <= '0;
      st_q    <= '0;
      so_q    <= '0;
      en_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      mt_q    <= mt_d;
      mo_q    <= mo_d;
      st_q    <= st_d;
      so_q    <= so_d;
      en_q    <= en_d;
    end
  end
  assign MT    = mt_q;
  assign MO    = mo_q;
  assign ST    = st_q;
  assign SO    = so_q;
  assign EN    = en_q;
  assign STATE = state_q;
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: directed self-checking bench for stopwatch_counter
module tb_stopwatch_counter;
  logic clk = 0, rst = 0, one_hz = 0, adj_tick = 0, pause = 0, adj = 0, sel = 0;
  logic [3:0] mt, mo, st, so;
  logic en;
  logic [1:0] state;
  int n_cmp = 0, n_err = 0;
  stopwatch_counter dut (
    .CLK(clk), .RST(rst), .ONE_HZ(one_hz), .ADJ_TICK(adj_tick), .PAUSE(pause),
    .ADJ(adj), .SEL(sel), .MT(mt), .MO(mo), .ST(st), .SO(so), .EN(en), .STATE(state)
  );
  always #5 clk = ~clk;
  task automatic cyc(input logic oh, at, ps);
    one_hz = oh; adj_tick = at; pause = ps;
    @(posedge clk); #1;
    one_hz = 0; adj_tick = 0; pause = 0;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [15:0] d, input logic e, input logic [1:0] s);
    chk({tag, ".disp"}, {mt, mo, st, so}, d);
    chk({tag, ".en"}, 16'(en), 16'(e));
    chk({tag, ".state"}, 16'(state), 16'(s));
  endtask
  initial begin
    rst = 1; cyc(0, 0, 0); rst = 0;
    chk_all("reset", 16'h0000, 1, 2'b00);
    repeat (3) cyc(1, 0, 0);
    chk_all("run3", 16'h0003, 1, 2'b00);
    rst = 1; cyc(0, 0, 0); rst = 0;
    chk_all("rst2", 16'h0000, 1, 2'b00);
    adj = 1; sel = 1; cyc(0, 0, 0);
    chk_all("enter_adj", 16'h0000, 1, 2'b10);
    for (int i = 0; i < 59; i++) cyc(0, 1, 0);
    chk_all("pre0059", 16'h0059, 0, 2'b10);
    adj = 0; cyc(0, 0, 0);
    chk_all("exit_run", 16'h0059, 1, 2'b00);
    cyc(1, 0, 0);
    chk("carry_min", {mt, mo, st, so}, 16'h0100);
    adj = 1; sel = 0; cyc(0, 0, 0);
    for (int i = 0; i < 58; i++) cyc(0, 1, 0);
    sel = 1;
    for (int i = 0; i < 59; i++) cyc(0, 1, 0);
    adj = 0; cyc(0, 0, 0);
    chk_all("pre5959", 16'h5959, 1, 2'b00);
    cyc(1, 0, 0);
    chk_all("wrap", 16'h0000, 1, 2'b00);
    cyc(0, 0, 1);
    chk("pause.state", 16'(state), 16'h1);
    repeat (5) cyc(1, 0, 0);
    chk_all("paused_hold", 16'h0000, 1, 2'b01);
    cyc(0, 0, 1);
    chk("resume.state", 16'(state), 16'h0);
    cyc(1, 0, 0);
    chk("resume.disp", {mt, mo, st, so}, 16'h0001);
    cyc(1, 0, 1);
    chk_all("coinc_pause", 16'h0002, 1, 2'b01);
    adj = 1; sel = 1; cyc(0, 0, 0);
    chk_all("adj_from_pause", 16'h0002, 1, 2'b10);
    for (int i = 0; i < 56; i++) cyc(0, 1, 0);
    chk_all("at0058", 16'h0058, 1, 2'b10);
    cyc(0, 1, 0);
    chk_all("s59", 16'h0059, 0, 2'b10);
    cyc(0, 1, 0);
    chk_all("s_wrap", 16'h0000, 1, 2'b10);
    cyc(0, 1, 0);
    chk_all("s01", 16'h0001, 0, 2'b10);
    cyc(0, 0, 1);
    chk_all("pause_in_adj", 16'h0001, 0, 2'b10);
    sel = 0;
    for (int i = 0; i < 59; i++) cyc(0, 1, 0);
    chk_all("m59", 16'h5901, 1, 2'b10);
    repeat (2) cyc(0, 1, 0);
    chk_all("m_wrap", 16'h0101, 1, 2'b10);
    sel = 1; cyc(1, 1, 0);
    chk_all("coinc_tick", 16'h0102, 0, 2'b10);
    cyc(1, 0, 0);
    chk_all("onehz_in_adj", 16'h0102, 0, 2'b10);
    adj = 0; cyc(0, 0, 0);
    chk_all("exit_paused", 16'h0102, 1, 2'b01);
    cyc(0, 0, 1);
    adj = 1; cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk_all("adj_from_run", 16'h0103, 0, 2'b10);
    rst = 1; cyc(1, 1, 0); rst = 0; adj = 0;
    chk_all("rst_mid_adj", 16'h0000, 1, 2'b00);
    cyc(1, 0, 0);
    chk_all("post_rst_run", 16'h0001, 1, 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
Time-keeping core of the stopwatch; sits directly upstream of the 7-segment display multiplexer. Holds a BCD minutes:seconds count (00:00–59:59) that advances on a 1 Hz tick and supports pause/resume and an adjust mode. Drives the display's four BCD digit inputs and its enable, which blinks the display while adjusting.

Parameters:
MIN_MAX, 59, terminal value of the minutes field (decimal, BCD-encoded internally)
SEC_MAX, 59, terminal value of the seconds field (decimal, BCD-encoded internally)

Ports:
CLK  input  1  system clock
RST  input  1  reset; synchronous, active-high
ONE_HZ  input  1  single-CLK-cycle pulse, 1 Hz; count advance
ADJ_TICK  input  1  single-CLK-cycle pulse, 2 Hz; adjust-mode increment and blink rate
PAUSE  input  1  debounced single-cycle pulse; toggles run/pause
ADJ  input  1  level; 1 = adjust mode
SEL  input  1  level; adjust target: 0 = minutes, 1 = seconds
MT  output  4  minutes tens, BCD 0–5
MO  output  4  minutes ones, BCD 0–9
ST  output  4  seconds tens, BCD 0–5
SO  output  4  seconds ones, BCD 0–9
EN  output  1  display enable; 0 blanks all digits
STATE  output  2  00 = RUN, 01 = PAUSED, 10 = ADJUST (debug)

Behaviour:
- All outputs registered. Every update occurs on the CLK edge that samples the qualifying input high and is visible in the following cycle.
- RST (synchronous, priority over everything): MT/MO/ST/SO = 0, EN = 1, STATE = RUN, saved-run flag = RUN.
- FSM, three states:
  - RUN: ONE_HZ increments seconds.
  - PAUSED: count held.
  - ADJUST: ONE_HZ ignored.
- Transitions, ADJ has priority:
  - ADJ=1 in RUN or PAUSED -> ADJUST; the current state is saved.
  - ADJ=0 in ADJUST -> saved state.
  - PAUSE pulse toggles RUN <-> PAUSED.
  - PAUSE is ignored in ADJUST and in any cycle where ADJ=1.
- Run increment:
  - SO 9->0 carries into ST; ST 5 with SO 9 -> ST 0 and carries into MO.
  - MO 9->0 carries into MT.
  - 59:59 -> 00:00, wrap with no flag.
- A PAUSE pulse in the same cycle as ONE_HZ while in RUN: the increment is applied and the state becomes PAUSED.
- ADJUST increment, once per ADJ_TICK:
  - SEL=1: seconds +1, 59 -> 00, no carry into minutes.
  - SEL=0: minutes +1, 59 -> 00; seconds unchanged.
  - SEL is sampled in the same cycle as ADJ_TICK; a SEL change takes effect on the next tick.
- EN:
  - Constant 1 outside ADJUST.
  - In ADJUST, toggles on each ADJ_TICK, starting from 1 at entry; the first tick drives it to 0 on the same edge as the first increment.
  - Leaving ADJUST forces EN = 1 on the exit edge.
- Coincident ONE_HZ and ADJ_TICK in ADJUST: only ADJ_TICK acts.
- Illegal BCD (not reachable from reset): a digit above its max is treated as at max and wraps to 0 on the next increment.
- RST asserted mid-adjust or mid-carry: result is exactly the reset values; there is no partial update.

Test Plan:
- RST, then 3 ONE_HZ pulses -> MT/MO/ST/SO = 0/0/0/3, STATE=00, EN=1. RST again -> all zero in 1 cycle.
- Preload to 00:59 via adjust, exit to RUN, 1 ONE_HZ -> 01:00. Preload 59:59, 1 ONE_HZ -> 00:00.
- RUN, PAUSE pulse, 5 ONE_HZ pulses -> count unchanged, STATE=01. Second PAUSE, 1 ONE_HZ -> +1 s. PAUSE and ONE_HZ coincident -> +1 s, then paused.
- ADJ=1, SEL=1 from 00:58: 3 ADJ_TICK -> 00:01 (no minute carry), EN 1->0->1->0. SEL=0, 2 ADJ_TICK from 59:xx -> 01:xx. ADJ=0 -> EN=1 next cycle.
- Enter ADJUST from PAUSED, exit -> STATE=01. PAUSE pulse during ADJUST -> ignored; state after exit unchanged.
- In ADJUST, ONE_HZ coincident with ADJ_TICK, SEL=1 at 00:10 -> 00:11 (single step). ONE_HZ alone -> no change.
